// File: rtl/hmc_link_seq_pkg.sv
// Shared types for the HMC link-mode sequencer: FSM state encoding, the
// symmetric link configuration record and the illegal-request error code.
package hmc_link_seq_pkg;

    // Widest clock-ratio field the configuration record can carry.
    localparam int RATIO_W_MAX = 16;

    localparam logic [2:0] ERR_LINK_REQ = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUIESCE,
        ST_APPLY,
        ST_TRAIN,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } seq_state_e;

    typedef struct packed {
        logic [2:0]             cid;
        logic [RATIO_W_MAX-1:0] clk_ratio;
        logic                   half_link;
    } link_cfg_t;

    // A zero clock ratio cannot be programmed into any link.
    function automatic logic cfg_legal(input link_cfg_t cfg);
        return cfg.clk_ratio != '0;
    endfunction

endpackage

// File: rtl/hmc_link_seq_timer.sv
// Loadable down-counter with expiry flag, used as the per-phase wait watchdog
// when the sequencer is built with HMC_LINK_SEQ_TIMEOUT_EN.
module hmc_link_seq_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    // Expiry means the current cycle is the last one allowed in the phase.
    assign expired = (cnt_reg == '0);

endmodule

// File: rtl/hmc_link_mode_seq.sv
// Applies one symmetric link-mode configuration to every HMC link in turn:
// quiesce, write, retrain, next. Optional wait-phase timeout: HMC_LINK_SEQ_TIMEOUT_EN.
module hmc_link_mode_seq
    import hmc_link_seq_pkg::*;
#(
    parameter int NUM_LINKS      = 4,
    parameter int RATIO_W        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 REFCLKP,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_cid,
    input  logic [RATIO_W-1:0]   req_clk_ratio,
    input  logic                 req_half_link,
    output logic [2:0]           cfg_cid,
    output logic [RATIO_W-1:0]   cfg_clk_ratio,
    output logic                 cfg_half_link,
    output logic [NUM_LINKS-1:0] lnk_quiesce,
    input  logic [NUM_LINKS-1:0] lnk_idle,
    output logic [NUM_LINKS-1:0] lnk_cfg_wr,
    output logic [NUM_LINKS-1:0] lnk_train,
    input  logic [NUM_LINKS-1:0] lnk_trained,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2:0]           err_link
);

    localparam int IDX_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_LINKS - 1);
    localparam logic [NUM_LINKS-1:0] FIRST_SEL = NUM_LINKS'(1);

    seq_state_e             state_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [2:0]             cfg_cid_reg;
    logic [RATIO_W-1:0]     cfg_clk_ratio_reg;
    logic                   cfg_half_link_reg;
    logic [NUM_LINKS-1:0]   lnk_quiesce_reg;
    logic [NUM_LINKS-1:0]   lnk_cfg_wr_reg;
    logic [NUM_LINKS-1:0]   lnk_train_reg;
    logic                   req_ready_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   err_reg;
    logic [2:0]             err_link_reg;

    logic [NUM_LINKS-1:0]   sel_onehot;
    logic                   idle_sel;
    logic                   trained_sel;
    logic                   waiting;
    logic                   wait_timeout;
    link_cfg_t              req_cfg;
    logic                   req_legal;

    for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_sel
        assign sel_onehot[gi] = (idx_reg == IDX_W'(gi));
    end

    // Handshakes from links other than the selected one are masked off.
    assign idle_sel    = |(lnk_idle & sel_onehot);
    assign trained_sel = |(lnk_trained & sel_onehot);
    assign waiting     = (state_reg == ST_QUIESCE) || (state_reg == ST_TRAIN);

    assign req_cfg.cid       = req_cid;
    assign req_cfg.clk_ratio = RATIO_W_MAX'(req_clk_ratio);
    assign req_cfg.half_link = req_half_link;
    assign req_legal         = cfg_legal(req_cfg);

`ifdef HMC_LINK_SEQ_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic tmr_expired;

    // Reloaded in every non-wait cycle, so each wait phase starts with a full budget.
    hmc_link_seq_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (REFCLKP),
        .srst     (rst),
        .load     (!waiting),
        .load_val (TMR_W'(TIMEOUT_CYCLES - 1)),
        .en       (waiting),
        .expired  (tmr_expired)
    );

    assign wait_timeout = tmr_expired;
`else
    // Without the timer a wait phase can only end by its handshake.
    assign wait_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge REFCLKP) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            idx_reg           <= '0;
            cfg_cid_reg       <= '0;
            cfg_clk_ratio_reg <= '0;
            cfg_half_link_reg <= 1'b0;
            lnk_quiesce_reg   <= '0;
            lnk_cfg_wr_reg    <= '0;
            lnk_train_reg     <= '0;
            req_ready_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            err_reg           <= 1'b0;
            err_link_reg      <= '0;
        end else begin
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            lnk_cfg_wr_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (!req_legal) begin
                            state_reg    <= ST_ERR;
                            err_reg      <= 1'b1;
                            err_link_reg <= ERR_LINK_REQ;
                        end else begin
                            state_reg         <= ST_QUIESCE;
                            idx_reg           <= '0;
                            cfg_cid_reg       <= req_cid;
                            cfg_clk_ratio_reg <= req_clk_ratio;
                            cfg_half_link_reg <= req_half_link;
                            lnk_quiesce_reg   <= FIRST_SEL;
                        end
                    end
                end
                ST_QUIESCE: begin
                    if (idle_sel) begin
                        state_reg      <= ST_APPLY;
                        lnk_cfg_wr_reg <= sel_onehot;
                    end else if (wait_timeout) begin
                        state_reg       <= ST_ERR;
                        err_reg         <= 1'b1;
                        err_link_reg    <= 3'(idx_reg);
                        lnk_quiesce_reg <= '0;
                        lnk_train_reg   <= '0;
                    end
                end
                ST_APPLY: begin
                    state_reg     <= ST_TRAIN;
                    lnk_train_reg <= sel_onehot;
                end
                ST_TRAIN: begin
                    if (trained_sel) begin
                        state_reg       <= ST_NEXT;
                        lnk_quiesce_reg <= '0;
                        lnk_train_reg   <= '0;
                    end else if (wait_timeout) begin
                        state_reg       <= ST_ERR;
                        err_reg         <= 1'b1;
                        err_link_reg    <= 3'(idx_reg);
                        lnk_quiesce_reg <= '0;
                        lnk_train_reg   <= '0;
                    end
                end
                ST_NEXT: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg       <= ST_QUIESCE;
                        idx_reg         <= idx_reg + IDX_W'(1);
                        lnk_quiesce_reg <= sel_onehot << 1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_reg     <= ST_IDLE;
                    busy_reg      <= 1'b0;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    busy_reg        <= 1'b0;
                    req_ready_reg   <= 1'b1;
                    lnk_quiesce_reg <= '0;
                    lnk_train_reg   <= '0;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_reg;
    assign cfg_cid       = cfg_cid_reg;
    assign cfg_clk_ratio = cfg_clk_ratio_reg;
    assign cfg_half_link = cfg_half_link_reg;
    assign lnk_quiesce   = lnk_quiesce_reg;
    assign lnk_cfg_wr    = lnk_cfg_wr_reg;
    assign lnk_train     = lnk_train_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign err           = err_reg;
    assign err_link      = err_link_reg;

endmodule

// File: tb/tb_hmc_link_mode_seq.sv
// Scoreboard bench for hmc_link_mode_seq: expected writes and done/err events
// are queued when a request is driven and matched as the DUT produces them.
module tb_hmc_link_mode_seq;

    localparam int NL = 4;
    localparam int RW = 4;
    localparam int TO = 16;

    logic          REFCLKP = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_cid = '0;
    logic [RW-1:0] req_clk_ratio = '0;
    logic          req_half_link = 1'b0;
    logic [2:0]    cfg_cid;
    logic [RW-1:0] cfg_clk_ratio;
    logic          cfg_half_link;
    logic [NL-1:0] lnk_quiesce;
    logic [NL-1:0] lnk_idle = '1;
    logic [NL-1:0] lnk_cfg_wr;
    logic [NL-1:0] lnk_train;
    logic [NL-1:0] lnk_trained = '1;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    err_link;

    hmc_link_mode_seq #(
        .NUM_LINKS      (NL),
        .RATIO_W        (RW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .REFCLKP       (REFCLKP),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cid       (req_cid),
        .req_clk_ratio (req_clk_ratio),
        .req_half_link (req_half_link),
        .cfg_cid       (cfg_cid),
        .cfg_clk_ratio (cfg_clk_ratio),
        .cfg_half_link (cfg_half_link),
        .lnk_quiesce   (lnk_quiesce),
        .lnk_idle      (lnk_idle),
        .lnk_cfg_wr    (lnk_cfg_wr),
        .lnk_train     (lnk_train),
        .lnk_trained   (lnk_trained),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_link      (err_link)
    );

    always #5 REFCLKP = ~REFCLKP;

    typedef struct {
        int link;
        int cid;
        int ratio;
        int half;
    } wr_exp_t;

    typedef struct {
        int is_err;
        int elink;
        int lat;
    } end_exp_t;

    wr_exp_t  wr_q[$];
    end_exp_t end_q[$];
    wr_exp_t  mon_wr;
    end_exp_t mon_end;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int acc_cnt = 0;
    int done_cyc = -100;
    int wr_cnt[NL];
    int qonly_cnt[NL];
    int train_cnt[NL];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: samples DUT outputs on the falling edge and drains the scoreboard.
    always @(negedge REFCLKP) begin
        cyc++;
        if (!rst) begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                acc_cnt++;
            end
            for (int i = 0; i < NL; i++) begin
                if (lnk_cfg_wr[i]) wr_cnt[i]++;
                if (lnk_quiesce[i] && !lnk_cfg_wr[i] && !lnk_train[i]) qonly_cnt[i]++;
                if (lnk_train[i]) train_cnt[i]++;
            end
            if (lnk_cfg_wr != '0) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'(lnk_cfg_wr), 0);
                end else begin
                    mon_wr = wr_q.pop_front();
                    check("wr_link", 32'(lnk_cfg_wr), 1 << mon_wr.link);
                    check("wr_quiesce", 32'(lnk_quiesce), 1 << mon_wr.link);
                    check("cfg_cid", 32'(cfg_cid), mon_wr.cid);
                    check("cfg_ratio", 32'(cfg_clk_ratio), mon_wr.ratio);
                    check("cfg_half", 32'(cfg_half_link), mon_wr.half);
                    $display("[TB] wr link %0d cfg {%0d,%0d,%0d} at cycle %0d",
                             mon_wr.link, cfg_cid, cfg_clk_ratio, cfg_half_link, cyc);
                end
            end
            if (done || err) begin
                if (done) done_cyc = cyc;
                if (end_q.size() == 0) begin
                    check("end_unexpected", {30'd0, done, err}, 0);
                end else begin
                    mon_end = end_q.pop_front();
                    check("end_err", 32'(err), mon_end.is_err);
                    check("end_done", 32'(done), (mon_end.is_err != 0) ? 0 : 1);
                    if (mon_end.is_err != 0) check("err_link", 32'(err_link), mon_end.elink);
                    if (mon_end.lat >= 0) check("end_latency", cyc - acc_cyc, mon_end.lat);
                    $display("[TB] %s err_link=%0d latency=%0d at cycle %0d",
                             done ? "done" : "err", err_link, cyc - acc_cyc, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge REFCLKP);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NL; i++) begin
            wr_cnt[i] = 0;
            qonly_cnt[i] = 0;
            train_cnt[i] = 0;
        end
    endtask

    task automatic push_seq(input int c, input int r, input int h, input int lat);
        for (int i = 0; i < NL; i++) wr_q.push_back('{link: i, cid: c, ratio: r, half: h});
        end_q.push_back('{is_err: 0, elink: 0, lat: lat});
    endtask

    task automatic send(input int c, input int r, input int h);
        int b;
        b = 0;
        while (!req_ready && b < 200) begin
            tick();
            b++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 1);
        req_cid       = 3'(c);
        req_clk_ratio = RW'(r);
        req_half_link = h[0];
        req_valid     = 1'b1;
        tick();
        req_valid     = 1'b0;
    endtask

    task automatic drain(input int budget);
        int b;
        b = 0;
        while ((wr_q.size() + end_q.size()) != 0 && b < budget) begin
            tick();
            b++;
        end
        check("drain", wr_q.size() + end_q.size(), 0);
        wr_q.delete();
        end_q.delete();
        tick();
    endtask

    task automatic wait_bit(input string tag, input int which, input int link);
        int b;
        b = 0;
        do begin
            @(negedge REFCLKP);
            b++;
        end while (((which == 0) ? !lnk_quiesce[link] : !lnk_train[link]) && b < 400);
        if (b >= 400) check(tag, 0, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        clear_counts();

        // Reset values, then req_ready rises once reset is released.
        tick();
        tick();
        @(negedge REFCLKP);
        check("rst_outputs", {5'd0, req_ready, busy, done, err, err_link, cfg_cid,
                              cfg_clk_ratio, cfg_half_link, lnk_quiesce, lnk_cfg_wr, lnk_train}, 0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge REFCLKP);
        check("ready_after_rst", 32'(req_ready), 1);
        check("busy_idle", 32'(busy), 0);

        // Best case: all handshakes high, links written in order, done after 17 cycles.
        push_seq(2, 5, 1, 17);
        send(2, 5, 1);
        drain(200);

        // Illegal ratio: immediate error, no link touched.
        end_q.push_back('{is_err: 1, elink: 7, lat: 1});
        send(2, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge REFCLKP);
            check("illegal_lnk_quiet", 32'(lnk_quiesce | lnk_cfg_wr | lnk_train), 0);
        end
        drain(50);
        @(negedge REFCLKP);
        check("ready_after_err", 32'(req_ready), 1);

        // Link 2 slow to drain: quiesce held, earlier links untouched.
        clear_counts();
        lnk_idle = 4'b1011;
        push_seq(3, 9, 0, -1);
        send(3, 9, 0);
        wait_bit("q2_timeout", 0, 2);
        repeat (50) @(negedge REFCLKP);
        check("q2_no_wr", 32'(lnk_cfg_wr[2]), 0);
        check("q2_held", 32'(lnk_quiesce), 32'h4);
        lnk_idle[2] = 1'b1;
        drain(300);
        check("q2_len", qonly_cnt[2], 51);
        check("l0_wr_once", wr_cnt[0], 1);
        check("l1_wr_once", wr_cnt[1], 1);
        check("l3_wr_once", wr_cnt[3], 1);

`ifdef HMC_LINK_SEQ_TIMEOUT_EN
        // Link 1 never trains: error after TO train cycles.
        clear_counts();
        lnk_trained = 4'b1101;
        wr_q.push_back('{link: 0, cid: 4, ratio: 2, half: 1});
        wr_q.push_back('{link: 1, cid: 4, ratio: 2, half: 1});
        end_q.push_back('{is_err: 1, elink: 1, lat: -1});
        send(4, 2, 1);
        drain(400);
        @(negedge REFCLKP);
        check("to_train_cycles", train_cnt[1], TO);
        check("to_lnk_clear", 32'(lnk_quiesce | lnk_cfg_wr | lnk_train), 0);
        check("to_ready", 32'(req_ready), 1);
        lnk_trained = '1;
        tick();
`endif

        // Reset during TRAIN of link 3, then a fresh request starts from link 0.
        for (int i = 0; i < NL; i++) wr_q.push_back('{link: i, cid: 6, ratio: 3, half: 0});
        send(6, 3, 0);
        wait_bit("t3_timeout", 1, 3);
        rst = 1'b1;
        @(negedge REFCLKP);
        check("midrst_outputs", {5'd0, req_ready, busy, done, err, err_link, cfg_cid,
                                 cfg_clk_ratio, cfg_half_link, lnk_quiesce, lnk_cfg_wr, lnk_train}, 0);
        check("midrst_wr_done", wr_q.size(), 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("midrst_no_end", {30'd0, done, err}, 0);
        clear_counts();
        push_seq(1, 15, 1, 17);
        send(1, 15, 1);
        drain(200);
        check("fresh_l0_wr", wr_cnt[0], 1);

        // Request held high while busy is taken only in the cycle after done.
        push_seq(5, 7, 0, 17);
        send(5, 7, 0);
        push_seq(2, 11, 1, 17);
        a0 = acc_cnt;
        req_cid       = 3'd2;
        req_clk_ratio = RW'(11);
        req_half_link = 1'b1;
        req_valid     = 1'b1;
        for (int b = 0; b < 300 && acc_cnt == a0; b++) tick();
        req_valid = 1'b0;
        check("hold_accepted", acc_cnt - a0, 1);
        check("hold_acc_gap", acc_cyc - done_cyc, 1);
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
